seg7_scan_driver: RTL



---
 rtl/seg7_scan_driver.sv | 88 ++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit seven-segment driver with a
// double-buffered value register, leading-zero blanking, per-digit blink and selectable polarity.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_BITS   = 16,
    parameter int BLINK_BITS = 6,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    input  logic                    lzb_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [6:0]              seg_out
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_POL = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};

    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [DIV_BITS-1:0]     r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [BLINK_BITS-1:0]   r_blink;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    w_tick;
    logic [3:0]              w_digit;
    logic [6:0]              w_dec;
    logic                    w_lz;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_an;
    logic [6:0]              w_seg;

    assign w_tick  = &r_presc;
    assign w_digit = r_shadow[{r_idx, 2'b00} +: 4];

    always_comb begin
        case (w_digit)
            4'd0:    w_dec = 7'b0111111;
            4'd1:    w_dec = 7'b0000110;
            4'd2:    w_dec = 7'b1011011;
            4'd3:    w_dec = 7'b1001111;
            4'd4:    w_dec = 7'b1100110;
            4'd5:    w_dec = 7'b1101101;
            4'd6:    w_dec = 7'b1111101;
            4'd7:    w_dec = 7'b0000111;
            4'd8:    w_dec = 7'b1111111;
            4'd9:    w_dec = 7'b1101111;
            default: w_dec = 7'b1000000;
        endcase
    end

    // set while every shadow digit from idx upward is zero
    always_comb begin
        w_lz = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (i >= int'(r_idx) && r_shadow[4*i +: 4] != 4'd0) w_lz = 1'b0;
    end

    assign w_blank = (lzb_en && r_idx != '0 && w_lz) || (blink_mask[r_idx] && r_blink[BLINK_BITS-1]);
    assign w_an    = w_blank ? '0 : NUM_DIGITS'(1) << r_idx;
    assign w_seg   = w_blank ? '0 : w_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
            r_presc  <= '0;
            r_idx    <= '0;
            r_blink  <= '0;
            r_an     <= AN_POL;
            r_seg    <= SEG_POL;
        end else begin
            if (load) r_shadow <= bcd_in;
            r_presc <= r_presc + DIV_BITS'(1);
            if (w_tick) begin
                r_idx   <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
                r_blink <= r_blink + BLINK_BITS'(1);
            end
            r_an  <= w_an ^ AN_POL;
            r_seg <= w_seg ^ SEG_POL;
        end
    end

    assign an_out  = r_an;
    assign seg_out = r_seg;
endmodule
